icache_dm: RTL and testbench

- Direct-mapped, one-word-per-line instruction cache.
- Sits between the pipeline's fetch port (imemREN/imemaddr -> ihit/imemload) and the memory controller instruction port (iREN/iaddr <- iwait/iload).
- Hits return in the same cycle. Misses run a blocking fill FSM.
- Downstream consumer of the datapath's instruction requests; replaces the direct fetch path.

---
 rtl/icache_dm_pkg.sv | 33 +++
 rtl/icache_dm_if.sv | 30 +++
 rtl/icache_dm.sv | 107 ++++++++++
 tb/tb_icache_dm.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_dm_pkg.sv
`default_nettype none
// ============================================================================
// icache_dm_pkg : shared types for the direct-mapped instruction cache
// Rev 1.0
// ============================================================================
package icache_dm_pkg;

  typedef logic [31:0] word_t;

  // Default cache geometry; icache_dm re-derives these from its SETS parameter.
  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_dm_if.sv
`default_nettype none
// ============================================================================
// icache_dm_if : fetch-side and memory-side signals of the instruction cache
// Rev 1.0
// ============================================================================
interface icache_dm_if;
  import icache_dm_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  // slave: the cache itself; master: datapath fetch stage plus memory controller
  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

endinterface
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// icache_dm : direct-mapped, one-word-per-line instruction cache, blocking fill
// Optional hit/miss counters enabled by defining ICACHE_STATS_EN.   Rev 1.0
// ============================================================================
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic          CLK,
  input  logic          nRST,
  icache_dm_if.slave    bus
`ifdef ICACHE_STATS_EN
  ,
  output word_t         hit_count,
  output word_t         miss_count
`endif
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } fetch_addr_t;

  icache_state_t    state;
  fetch_addr_t      req;
  fetch_addr_t      miss_q;
  logic             iren_q;
  logic [SETS-1:0]  valid_bits;
  logic [TAG_W-1:0] tag_arr  [SETS];
  word_t            data_arr [SETS];

  logic hit;
  logic miss;
  logic fill_done;
  logic unused_bytoff;

  assign req           = fetch_addr_t'(bus.imemaddr);
  assign unused_bytoff = ^req.bytoff;

  assign hit       = (state == IDLE) && bus.imemREN && valid_bits[req.idx]
                     && (tag_arr[req.idx] == req.tag);
  assign miss      = (state == IDLE) && bus.imemREN && !hit;
  assign fill_done = (state == FILL) && !bus.iwait;

  assign bus.ihit     = hit;
  assign bus.imemload = ((state == IDLE) && bus.imemREN) ? data_arr[req.idx] : '0;
  assign bus.iREN     = iren_q;
  assign bus.iaddr    = word_t'(miss_q);

  // Only valid bits need reset; an aborted fill never touches the arrays
  // because the asynchronous reset drops the FSM out of FILL at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      iren_q     <= 1'b0;
      miss_q     <= '0;
      valid_bits <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            state  <= FILL;
            iren_q <= 1'b1;
            miss_q <= '{tag: req.tag, idx: req.idx, bytoff: 2'b00};
          end
        end
        FILL: begin
          if (!bus.iwait) begin
            state               <= IDLE;
            iren_q              <= 1'b0;
            valid_bits[miss_q.idx] <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          iren_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_arr[miss_q.idx]  <= miss_q.tag;
      data_arr[miss_q.idx] <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)  hit_count  <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
// tb_icache_dm : directed scenarios plus random fetch traffic for icache_dm,
// checked against an address-level cache model. Rev 1.0
// ============================================================================
module tb_icache_dm;
  import icache_dm_pkg::*;

  localparam int SETS = 16;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  icache_dm_if bus ();

`ifdef ICACHE_STATS_EN
  word_t hit_count;
  word_t miss_count;
`endif

  icache_dm #(.SETS(SETS)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backing memory: explicit words where the scenarios need them, a hash elsewhere.
  word_t mem [word_t];

  function automatic word_t mem_rd(input word_t a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Reference model: each set remembers the full word address it holds.
  bit          line_ok   [SETS];
  word_t       line_addr [SETS];
  word_t       line_data [SETS];
  bit          in_fill;
  word_t       fill_addr;
  int unsigned m_hits;
  int unsigned m_misses;
  bit          last_hit;
  word_t       last_load;

  function automatic int set_of(input word_t a);
    return int'((a >> 2) % SETS);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) line_ok[i] = 1'b0;
    in_fill   = 1'b0;
    fill_addr = '0;
    m_hits    = 0;
    m_misses  = 0;
  endtask

  task automatic step(input bit ren, input word_t addr, input bit wt);
    word_t wa;
    bit    exp_hit;
    int    s;
    wa = addr & 32'hFFFF_FFFC;
    s  = set_of(wa);
    @(posedge CLK);
    #1;
    bus.imemREN  = ren;
    bus.imemaddr = addr;
    bus.iwait    = wt;
    bus.iload    = wt ? $urandom : mem_rd(fill_addr);
    exp_hit = !in_fill && ren && line_ok[s] && (line_addr[s] == wa);
    @(negedge CLK);
    check("ihit", {31'd0, bus.ihit}, {31'd0, exp_hit});
    check("iREN", {31'd0, bus.iREN}, {31'd0, in_fill});
    if (in_fill) check("iaddr", bus.iaddr, fill_addr);
    if (exp_hit) check("imemload", bus.imemload, line_data[s]);
    else if (!ren) check("imemload_idle", bus.imemload, 32'd0);
`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
`endif
    last_hit  = bus.ihit;
    last_load = bus.imemload;
    if (in_fill) begin
      if (!wt) begin
        line_ok[set_of(fill_addr)]   = 1'b1;
        line_addr[set_of(fill_addr)] = fill_addr;
        line_data[set_of(fill_addr)] = mem_rd(fill_addr);
        in_fill = 1'b0;
      end
    end else if (ren) begin
      if (exp_hit) m_hits++;
      else begin
        m_misses++;
        in_fill   = 1'b1;
        fill_addr = wa;
      end
    end
  endtask

  // Hold a fetch until it hits; memory stays busy for lat cycles of each fill.
  task automatic fetch(input word_t addr, input int lat, output int cycles);
    int left;
    bit wt;
    left     = lat;
    cycles   = 0;
    last_hit = 1'b0;
    while (!last_hit && cycles < 64) begin
      wt = 1'b1;
      if (in_fill) begin
        wt = (left == 0) ? 1'b0 : 1'b1;
        if (left > 0) left--;
      end
      step(1'b1, addr, wt);
      cycles++;
    end
    check("fetch_hit", {31'd0, last_hit}, 32'd1);
  endtask

  task automatic hold_reset();
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    nRST         = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int    c;
    bit    ren;
    word_t addr;

    mem[32'h0000_0000] = 32'h2001_0005;
    mem[32'h0000_0004] = 32'hAAAA_0001;
    mem[32'h0000_0044] = 32'hBBBB_0002;

    hold_reset();
    #1;
    check("rst_ihit", {31'd0, bus.ihit}, 32'd0);
    check("rst_iREN", {31'd0, bus.iREN}, 32'd0);
    check("rst_iaddr", bus.iaddr, 32'd0);
    check("rst_imemload", bus.imemload, 32'd0);
`ifdef ICACHE_STATS_EN
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif

    // Cold miss, three busy cycles, then the replay hit.
    fetch(32'h0000_0000, 3, c);
    check("t1_latency", c, 32'd6);
    check("t1_load", last_load, 32'h2001_0005);

    fetch(32'h0000_0000, 0, c);
    check("t2_latency", c, 32'd1);
    check("t2_load", last_load, 32'h2001_0005);

    // imemREN low over a resident line: no hit, no request.
    step(1'b0, 32'h0000_0000, 1'b1);
    check("t6_ihit", {31'd0, bus.ihit}, 32'd0);
    check("t6_iREN", {31'd0, bus.iREN}, 32'd0);
`ifdef ICACHE_STATS_EN
    check("t2_hit_count", hit_count, 32'd2);
    check("t2_miss_count", miss_count, 32'd1);
`endif

    // Same set, different tag: each fetch evicts the other.
    fetch(32'h0000_0004, 1, c);
    check("t3_load_a", last_load, 32'hAAAA_0001);
    fetch(32'h0000_0044, 2, c);
    check("t3_conflict_latency", c, 32'd5);
    check("t3_load_b", last_load, 32'hBBBB_0002);
    fetch(32'h0000_0004, 0, c);
    check("t3_evicted_latency", c, 32'd3);

    // Redirect mid-fill: the fill finishes to the old address first.
    step(1'b1, 32'h0000_0100, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b1);
    check("t4_iaddr_held", bus.iaddr, 32'h0000_0100);
    step(1'b1, 32'h0000_0200, 1'b0);
    fetch(32'h0000_0200, 1, c);
    check("t4_new_miss_latency", c, 32'd4);
    // 0x100 and 0x200 share set 0 with 16 sets, so 0x100 was evicted.
    fetch(32'h0000_0100, 0, c);
    check("t4_refetch_latency", c, 32'd3);

    // Reset in the middle of a fill.
    step(1'b1, 32'h0000_0008, 1'b1);
    step(1'b1, 32'h0000_0008, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    check("t5_iREN_async", {31'd0, bus.iREN}, 32'd0);
    hold_reset();
    fetch(32'h0000_0008, 0, c);
    check("t5_refetch_latency", c, 32'd3);

    // Random traffic over a small address pool to provoke hits and conflicts.
    addr = '0;
    for (int i = 0; i < 600; i++) begin
      ren = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0)
        addr = (word_t'($urandom_range(0, 3)) << 6) | (word_t'($urandom_range(0, SETS - 1)) << 2)
               | word_t'($urandom_range(0, 3));
      step(ren, addr, ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
